// File: rtl/spi_reg_arb_pkg.sv
// Shared types and constants for the SPI register-bank arbiter.
package spi_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWN_SPI = 2'b01,
    OWN_LOC = 2'b10
  } arb_state_e;

  typedef enum logic {
    REQ_SPI = 1'b0,
    REQ_LOC = 1'b1
  } req_id_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_SPI  = 2'b01;
  localparam logic [1:0] OWNER_LOC  = 2'b10;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin grant with a per-requester mask; the pointer holds the
// id granted last and can be forced by the lock FSM on timeout.
module spi_rr_arb2
  import spi_reg_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       force_en,
  input  req_id_e    force_id,
  output logic [1:0] gnt
);

  req_id_e    last;
  logic [1:0] eff;

  always_comb begin
    eff = req & mask;
    gnt = eff;
    if (eff == 2'b11) begin
      gnt = (last == REQ_LOC) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= REQ_LOC;
    end else if (force_en) begin
      last <= force_id;
    end else if (gnt[0]) begin
      last <= REQ_SPI;
    end else if (gnt[1]) begin
      last <= REQ_LOC;
    end
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Register bank shared by the SPI engine and a local agent: one access per
// cycle, round-robin on ties, optional lock with a bounded hold time.
//
// state   | meaning
// IDLE    | no lock held, either requester may be granted
// OWN_SPI | SPI holds the lock, only SPI may be granted
// OWN_LOC | local agent holds the lock, only local may be granted
module spi_reg_arbiter
  import spi_reg_arb_pkg::*;
#(
  parameter int  NUM_REGS = 8,
  parameter int  WIDTH    = 8,
  parameter int  LOCK_MAX = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_req,
  input  logic                      spi_we,
  input  logic                      spi_lock,
  input  logic [ADDR_W-1:0]         spi_addr,
  input  logic [WIDTH-1:0]          spi_wdata,
  output logic                      spi_gnt,
  output logic                      spi_rvalid,
  output logic [WIDTH-1:0]          spi_rdata,
  input  logic                      loc_req,
  input  logic                      loc_we,
  input  logic                      loc_lock,
  input  logic [ADDR_W-1:0]         loc_addr,
  input  logic [WIDTH-1:0]          loc_wdata,
  output logic                      loc_gnt,
  output logic                      loc_rvalid,
  output logic [WIDTH-1:0]          loc_rdata,
  output logic [NUM_REGS*WIDTH-1:0] regs_o,
  output logic [1:0]                lock_owner
);

  localparam int                CNT_W    = $clog2(LOCK_MAX);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_MAX - 1);
  localparam logic [ADDR_W:0]   REGS_LIM = (ADDR_W + 1)'(NUM_REGS);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [CNT_W-1:0]  lock_cnt;
  logic              timeout;
  logic [1:0]        mask;
  logic [1:0]        gnt;
  logic              force_en;
  req_id_e           force_id;

  logic [WIDTH-1:0]  regs [NUM_REGS];
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [WIDTH-1:0]  acc_wdata;
  logic              acc_in_range;
  logic [WIDTH-1:0]  rd_val;

  // Gating the mask with rst keeps the grants low during reset.
  always_comb begin
    mask = 2'b11;
    case (state)
      OWN_SPI: mask = 2'b01;
      OWN_LOC: mask = 2'b10;
      default: mask = 2'b11;
    endcase
    if (rst) mask = 2'b00;
  end

  spi_rr_arb2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      ({loc_req, spi_req}),
    .mask     (mask),
    .force_en (force_en),
    .force_id (force_id),
    .gnt      (gnt)
  );

  assign spi_gnt = gnt[0];
  assign loc_gnt = gnt[1];
  assign timeout = (lock_cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    force_en  = 1'b0;
    force_id  = REQ_SPI;
    case (state)
      IDLE: begin
        if (gnt[0] && spi_lock) begin
          state_nxt = OWN_SPI;
        end else if (gnt[1] && loc_lock) begin
          state_nxt = OWN_LOC;
        end
      end
      OWN_SPI: begin
        if (timeout) begin
          state_nxt = IDLE;
          force_en  = 1'b1;
          force_id  = REQ_SPI;
        end else if ((gnt[0] && !spi_lock) || (!spi_req && !spi_lock)) begin
          state_nxt = IDLE;
        end
      end
      OWN_LOC: begin
        if (timeout) begin
          state_nxt = IDLE;
          force_en  = 1'b1;
          force_id  = REQ_LOC;
        end else if ((gnt[1] && !loc_lock) || (!loc_req && !loc_lock)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter clears on entry and counts only while the same lock is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != IDLE) && (state_nxt == state)) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end else begin
        lock_cnt <= '0;
      end
    end
  end

  always_comb begin
    lock_owner = OWNER_NONE;
    case (state)
      OWN_SPI: lock_owner = OWNER_SPI;
      OWN_LOC: lock_owner = OWNER_LOC;
      default: lock_owner = OWNER_NONE;
    endcase
  end

  assign acc_we       = gnt[1] ? loc_we    : spi_we;
  assign acc_addr     = gnt[1] ? loc_addr  : spi_addr;
  assign acc_wdata    = gnt[1] ? loc_wdata : spi_wdata;
  assign acc_in_range = ({1'b0, acc_addr} < REGS_LIM);
  assign rd_val       = acc_in_range ? regs[acc_addr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if ((|gnt) && acc_we && acc_in_range) begin
      regs[acc_addr] <= acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_rvalid <= 1'b0;
      spi_rdata  <= '0;
      loc_rvalid <= 1'b0;
      loc_rdata  <= '0;
    end else begin
      spi_rvalid <= gnt[0] && !spi_we;
      loc_rvalid <= gnt[1] && !loc_we;
      if (gnt[0] && !spi_we) spi_rdata <= rd_val;
      if (gnt[1] && !loc_we) loc_rdata <= rd_val;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Scoreboard bench for spi_reg_arbiter: a register model predicts reads, which
// are queued at grant time and popped when rvalid appears.
module tb_spi_reg_arbiter;

  localparam int NR = 6;
  localparam int W  = 8;
  localparam int AW = $clog2(NR);

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_req, spi_we, spi_lock;
  logic [AW-1:0] spi_addr;
  logic [W-1:0]  spi_wdata;
  logic          spi_gnt, spi_rvalid;
  logic [W-1:0]  spi_rdata;
  logic          loc_req, loc_we, loc_lock;
  logic [AW-1:0] loc_addr;
  logic [W-1:0]  loc_wdata;
  logic          loc_gnt, loc_rvalid;
  logic [W-1:0]  loc_rdata;
  logic [NR*W-1:0] regs_o;
  logic [1:0]    lock_owner;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model [NR];
  logic [W-1:0] spi_q [$];
  logic [W-1:0] loc_q [$];
  logic         pend_spi = 1'b0;
  logic         pend_loc = 1'b0;

  always #5 clk = ~clk;

  spi_reg_arbiter #(.NUM_REGS(NR), .WIDTH(W), .LOCK_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .spi_req(spi_req), .spi_we(spi_we), .spi_lock(spi_lock),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_gnt(spi_gnt), .spi_rvalid(spi_rvalid), .spi_rdata(spi_rdata),
    .loc_req(loc_req), .loc_we(loc_we), .loc_lock(loc_lock),
    .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_gnt(loc_gnt), .loc_rvalid(loc_rvalid), .loc_rdata(loc_rdata),
    .regs_o(regs_o), .lock_owner(lock_owner)
  );

  task automatic set_spi(input logic r, input logic we, input logic lk,
                         input int a, input logic [W-1:0] d);
    spi_req = r; spi_we = we; spi_lock = lk; spi_addr = AW'(a); spi_wdata = d;
  endtask

  task automatic set_loc(input logic r, input logic we, input logic lk,
                         input int a, input logic [W-1:0] d);
    loc_req = r; loc_we = we; loc_lock = lk; loc_addr = AW'(a); loc_wdata = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) model[i] = '0;
    spi_q.delete();
    loc_q.delete();
    pend_spi = 1'b0;
    pend_loc = 1'b0;
  endtask

  // One cycle: check grants, owner, registers and read returns at the
  // falling edge, then fold this cycle's expected accesses into the model.
  task automatic step(input logic es, input logic el, input logic [1:0] eo);
    logic [NR*W-1:0] er;
    logic [W-1:0]    ed;
    @(negedge clk);
    total++;
    if (spi_gnt !== es) begin
      bad++; $display("FAIL spi_gnt got=%b exp=%b t=%0t", spi_gnt, es, $time);
    end
    total++;
    if (loc_gnt !== el) begin
      bad++; $display("FAIL loc_gnt got=%b exp=%b t=%0t", loc_gnt, el, $time);
    end
    total++;
    if (lock_owner !== eo) begin
      bad++; $display("FAIL lock_owner got=%b exp=%b t=%0t", lock_owner, eo, $time);
    end
    for (int i = 0; i < NR; i++) er[i*W +: W] = model[i];
    total++;
    if (regs_o !== er) begin
      bad++; $display("FAIL regs_o got=%h exp=%h t=%0t", regs_o, er, $time);
    end
    total++;
    if (spi_rvalid !== pend_spi) begin
      bad++; $display("FAIL spi_rvalid got=%b exp=%b t=%0t", spi_rvalid, pend_spi, $time);
    end
    if (spi_rvalid === 1'b1) begin
      total++;
      if (spi_q.size() == 0) begin
        bad++; $display("FAIL spi_rdata got=%h exp=none t=%0t", spi_rdata, $time);
      end else begin
        ed = spi_q.pop_front();
        if (spi_rdata !== ed) begin
          bad++; $display("FAIL spi_rdata got=%h exp=%h t=%0t", spi_rdata, ed, $time);
        end
      end
    end
    total++;
    if (loc_rvalid !== pend_loc) begin
      bad++; $display("FAIL loc_rvalid got=%b exp=%b t=%0t", loc_rvalid, pend_loc, $time);
    end
    if (loc_rvalid === 1'b1) begin
      total++;
      if (loc_q.size() == 0) begin
        bad++; $display("FAIL loc_rdata got=%h exp=none t=%0t", loc_rdata, $time);
      end else begin
        ed = loc_q.pop_front();
        if (loc_rdata !== ed) begin
          bad++; $display("FAIL loc_rdata got=%h exp=%h t=%0t", loc_rdata, ed, $time);
        end
      end
    end
    pend_spi = es && !spi_we;
    pend_loc = el && !loc_we;
    if (pend_spi) spi_q.push_back((int'(spi_addr) < NR) ? model[spi_addr] : '0);
    if (pend_loc) loc_q.push_back((int'(loc_addr) < NR) ? model[loc_addr] : '0);
    if (es && spi_we && (int'(spi_addr) < NR)) model[spi_addr] = spi_wdata;
    if (el && loc_we && (int'(loc_addr) < NR)) model[loc_addr] = loc_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_spi(0, 0, 0, 0, 8'h00);
    set_loc(0, 0, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    step(0, 0, 2'b00);
    total++;
    if (spi_rdata !== 8'h00 || loc_rdata !== 8'h00) begin
      bad++; $display("FAIL reset_rdata got=%h/%h exp=00/00", spi_rdata, loc_rdata);
    end
  endtask

  task automatic test_basic();
    set_spi(1, 1, 0, 3, 8'hA5); step(1, 0, 2'b00);
    set_spi(1, 0, 0, 3, 8'h00); step(1, 0, 2'b00);
    set_spi(0, 0, 0, 0, 8'h00); step(0, 0, 2'b00);
    step(0, 0, 2'b00);
    total++;
    if (spi_rdata !== 8'hA5) begin
      bad++; $display("FAIL rdata_hold got=%h exp=a5", spi_rdata);
    end
  endtask

  // Last grant was SPI, so the tie sequence starts with local.
  task automatic test_round_robin();
    set_spi(1, 1, 0, 0, 8'h11);
    set_loc(1, 1, 0, 0, 8'h22);
    for (int i = 0; i < 6; i++) step(i[0], !i[0], 2'b00);
    set_spi(0, 0, 0, 0, 8'h00);
    set_loc(0, 0, 0, 0, 8'h00);
    step(0, 0, 2'b00);
  endtask

  task automatic test_lock();
    set_spi(1, 1, 0, 1, 8'h33);
    set_loc(1, 0, 1, 0, 8'h00);  step(0, 1, 2'b00);
    set_loc(0, 0, 1, 0, 8'h00);  step(0, 0, 2'b10);
    set_loc(1, 1, 0, 2, 8'h44);  step(0, 1, 2'b10);
    set_loc(0, 0, 0, 0, 8'h00);  step(1, 0, 2'b00);
    set_spi(0, 0, 0, 0, 8'h00);  step(0, 0, 2'b00);
  endtask

  task automatic test_timeout();
    set_loc(1, 1, 1, 4, 8'h55);  step(0, 1, 2'b00);
    set_loc(0, 0, 1, 0, 8'h00);
    set_spi(1, 0, 0, 4, 8'h00);
    for (int c = 1; c <= 16; c++) step(0, 0, 2'b10);
    step(1, 0, 2'b00);
    set_spi(0, 0, 0, 0, 8'h00);
    step(0, 0, 2'b00);
    step(0, 0, 2'b00);
    set_loc(0, 0, 0, 0, 8'h00);
  endtask

  task automatic test_out_of_range();
    set_spi(1, 1, 0, 6, 8'h77); step(1, 0, 2'b00);
    set_spi(1, 1, 0, 7, 8'h78); step(1, 0, 2'b00);
    set_spi(1, 0, 0, 7, 8'h00); step(1, 0, 2'b00);
    set_spi(1, 0, 0, 6, 8'h00); step(1, 0, 2'b00);
    set_spi(1, 0, 0, 4, 8'h00); step(1, 0, 2'b00);
    set_spi(0, 0, 0, 0, 8'h00); step(0, 0, 2'b00);
  endtask

  task automatic test_back_to_back();
    set_spi(1, 1, 0, 2, 8'h99); step(1, 0, 2'b00);
    set_spi(0, 0, 0, 0, 8'h00);
    set_loc(1, 0, 0, 2, 8'h00); step(0, 1, 2'b00);
    set_spi(1, 0, 0, 2, 8'h00);
    set_loc(1, 1, 0, 2, 8'hAA); step(1, 0, 2'b00);
    set_spi(0, 0, 0, 0, 8'h00); step(0, 1, 2'b00);
    set_loc(1, 0, 0, 2, 8'h00); step(0, 1, 2'b00);
    set_loc(0, 0, 0, 0, 8'h00); step(0, 0, 2'b00);
  endtask

  task automatic test_reset_mid_lock();
    set_spi(1, 0, 1, 2, 8'h00); step(1, 0, 2'b00);
    set_loc(1, 1, 0, 5, 8'h66);
    rst = 1'b1;
    step(0, 0, 2'b01);
    rst = 1'b0;
    clear_model();
    set_spi(1, 1, 0, 1, 8'h12);
    set_loc(1, 1, 0, 1, 8'h34); step(1, 0, 2'b00);
    total++;
    if (spi_rdata !== 8'h00 || loc_rdata !== 8'h00) begin
      bad++; $display("FAIL post_reset_rdata got=%h/%h exp=00/00", spi_rdata, loc_rdata);
    end
    set_spi(0, 0, 0, 0, 8'h00); step(0, 1, 2'b00);
    set_loc(0, 0, 0, 0, 8'h00); step(0, 0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_lock();
    test_timeout();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
